multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes and ALUop.
- Handles variable memory latency with a ready handshake and a bounded timeout.
- Traps on illegal or unsupported encodings.
- Sits between the instruction register and the datapath (PC, register file, ALU, data memory port).

Parameters:
ALUOP_W, 4, width of ALUop bus; must be >= 3; the 8 base ops occupy codes 0-7.
MEM_TIMEOUT, 16, maximum cycles to wait for mem_ready in FETCH or MEM before trapping; range 1..255.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
opCode  in  7  opcode field from the instruction register.
funct3  in  3  funct3 field.
funct7  in  7  funct7 field.
mem_ready  in  1  memory handshake; completes the current access.
branch_taken  in  1  ALU compare result, valid in EXEC.
pcWrite  out  1  load PC (sequential or branch/jump target).
irWrite  out  1  load instruction register.
memRead  out  1  memory read request (fetch or load).
memWrite  out  1  memory write request (store).
regWrite  out  1  register file write enable.
ALUop  out  ALUOP_W  ALU operation code (package constants).
state  out  3  current state encoding, for debug.
illegal  out  1  sticky trap flag.
mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, any state): state=FETCH, all strobes 0, ALUop=ADD, illegal=0, mem_err=0, timeout counter=0. Reset mid-access aborts the access.
- Outputs are Moore: decoded from the state register plus the instruction class and ALUop latched in DECODE. No output depends combinationally on opCode outside DECODE.
- FETCH: memRead=1 and is held until mem_ready.
  - In the mem_ready cycle, irWrite=1 and pcWrite=1 for exactly one cycle, then go to DECODE.
- DECODE (1 cycle): classify opCode.
  - Unknown opCode, or an unknown funct3/funct7 pair within a known class → TRAP.
  - Otherwise latch the class and ALUop, then go to EXEC.
- ALUop mapping:
  - R-type: add/sub/and/or/xor/slt/sll/srl.
  - I-type: addi→ADD, ori→OR, andi→AND.
  - LOAD/STORE/JAL/JALR: ADD.
  - BRANCH: SUB.
  - LUI: SLL.
- EXEC (1 cycle):
  - R/I/LUI → WB.
  - LOAD/STORE → MEM.
  - BRANCH: pcWrite=branch_taken for this cycle, then → FETCH. regWrite and memWrite stay 0.
  - JAL/JALR: pcWrite=1 for this cycle, then → WB to write the link.
- MEM: LOAD holds memRead=1; STORE holds memWrite=1; both held until mem_ready.
  - LOAD → WB; STORE → FETCH.
- WB: regWrite=1 for one cycle, then → FETCH.
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle without mem_ready.
  - When counter==MEM_TIMEOUT and mem_ready is still 0, go to TRAP and set mem_err.
  - mem_ready in that same cycle wins: normal completion, no error.
- TRAP: all strobes 0; illegal=1 (or mem_err=1); sticky; only reset exits.
- Latency with mem_ready tied high:
  - R/I/LUI/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE, BRANCH: 4 and 3 cycles.
- Strobe exclusivity: memRead and memWrite are never both 1; regWrite and memWrite are never both 1.

Optional Feature:
- Macro PERF_CNT_EN.
- With the macro defined:
  - Adds output instret (32 bits), incremented on each transition into FETCH from WB/EXEC/MEM, i.e. per retired instruction.
  - Adds output stall_cnt (32 bits), incremented each FETCH or MEM cycle with mem_ready=0.
  - Both counters reset to 0, wrap modulo 2^32, and freeze in TRAP.
- Without the macro: neither port nor the counter logic exists.

Decomposition:
- Shared package ctrl_pkg holds:
  - Opcode constants: R=0100001, I=0001101, LOAD=0000011, STORE=0010111, BRANCH=1100011, JAL=1101111, JALR=1000011, LUI=0100100.
  - funct3/funct7 constants.
  - ALUop codes ADD=0, SUB=1, AND=2, OR=3, SLL=4, SRL=5, XOR=6, SLT=7.
  - State enum and instruction-class enum.
- One combinational sub-module, instr_decoder, maps {opCode, funct3, funct7} to {class, ALUop, legal}. The FSM instantiates it.

Test Plan:
- Reset asserted mid-MEM with memWrite=1 → next sampled cycle shows state=FETCH, memWrite=0, ALUop=0.
- R-type sub (opCode 0100001, funct3 110, funct7 0), mem_ready=1 → ALUop=1 in EXEC; regWrite pulse exactly in cycle 4; irWrite and pcWrite pulse in cycle 1.
- LOAD with mem_ready low for 3 cycles in MEM → memRead held 4 cycles; regWrite 1 cycle later; mem_err=0.
- BRANCH, branch_taken=0 then 1 → pcWrite 0 then 1 in EXEC; regWrite=memWrite=0 throughout.
- opCode 1111111 → TRAP after DECODE; illegal=1 and held; strobes 0 for 20 cycles.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=16 → mem_err=1 after 17 FETCH cycles. With PERF_CNT_EN: stall_cnt=17, instret=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle control unit: opcode/funct
// encodings, ALUop codes, FSM state and instruction-class enums.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0100001;
  localparam logic [6:0] OP_I      = 7'b0001101;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1000011;
  localparam logic [6:0] OP_LUI    = 7'b0100100;

  // funct3 selects the R-type operation; I-type reuses ADD/OR/AND codes
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_SUB = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_R      = 3'd0,
    C_I      = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JAL    = 3'd5,
    C_JALR   = 3'd6,
    C_LUI    = 3'd7
  } iclass_t;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of {opCode, funct3, funct7} into instruction class,
// ALUop and a legality flag.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 4
) (
  input  logic [6:0]         i_opcode,
  input  logic [2:0]         i_funct3,
  input  logic [6:0]         i_funct7,
  output iclass_t            o_class,
  output logic [ALUOP_W-1:0] o_aluop,
  output logic               o_legal
);

  logic [2:0] w_op;

  // Class, base ALU operation and legality lookup
  always_comb begin
    o_class = C_R;
    w_op    = ALU_ADD;
    o_legal = 1'b1;
    case (i_opcode)
      OP_R: begin
        o_class = C_R;
        if (i_funct7 != F7_BASE) begin
          o_legal = 1'b0;
        end else begin
          case (i_funct3)
            F3_ADD:  w_op = ALU_ADD;
            F3_SUB:  w_op = ALU_SUB;
            F3_AND:  w_op = ALU_AND;
            F3_OR:   w_op = ALU_OR;
            F3_XOR:  w_op = ALU_XOR;
            F3_SLT:  w_op = ALU_SLT;
            F3_SLL:  w_op = ALU_SLL;
            F3_SRL:  w_op = ALU_SRL;
            default: o_legal = 1'b0;
          endcase
        end
      end
      // funct7 carries immediate bits for I-type, so only funct3 is checked
      OP_I: begin
        o_class = C_I;
        case (i_funct3)
          F3_ADD:  w_op = ALU_ADD;
          F3_OR:   w_op = ALU_OR;
          F3_AND:  w_op = ALU_AND;
          default: o_legal = 1'b0;
        endcase
      end
      OP_LOAD:   o_class = C_LOAD;
      OP_STORE:  o_class = C_STORE;
      OP_JAL:    o_class = C_JAL;
      OP_JALR:   o_class = C_JALR;
      OP_BRANCH: begin
        o_class = C_BRANCH;
        w_op    = ALU_SUB;
      end
      OP_LUI: begin
        o_class = C_LUI;
        w_op    = ALU_SLL;
      end
      default: o_legal = 1'b0;
    endcase
  end

  assign o_aluop = ALUOP_W'(w_op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and traps.
// Optional `PERF_CNT_EN adds instret and stall_cnt performance counters.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opCode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               mem_ready,
  input  logic               branch_taken,
  output logic               pcWrite,
  output logic               irWrite,
  output logic               memRead,
  output logic               memWrite,
  output logic               regWrite,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [2:0]         state,
  output logic               illegal,
  output logic               mem_err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        instret,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t             r_state;
  state_t             w_next;
  iclass_t            r_class;
  iclass_t            w_class;
  logic [ALUOP_W-1:0] r_aluop;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_legal;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_illegal;
  logic               r_mem_err;
  logic               w_mem_state;
  logic               w_timeout;
  logic               w_pc;
  logic               w_ir;
  logic               w_rd;
  logic               w_wr;
  logic               w_rg;

  instr_decoder #(.ALUOP_W(ALUOP_W)) u_dec (
    .i_opcode (opCode),
    .i_funct3 (funct3),
    .i_funct7 (funct7),
    .o_class  (w_class),
    .o_aluop  (w_aluop),
    .o_legal  (w_legal)
  );

  assign w_mem_state = is_mem_state(r_state);
  assign w_timeout   = w_mem_state && !mem_ready && (r_to_cnt == TO_LIMIT);

  // Next-state and strobe decode from the state register and latched class
  always_comb begin
    w_next = r_state;
    w_pc   = 1'b0;
    w_ir   = 1'b0;
    w_rd   = 1'b0;
    w_wr   = 1'b0;
    w_rg   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_rd = 1'b1;
        if (mem_ready) begin
          w_ir   = 1'b1;
          w_pc   = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_TRAP;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_R, C_I, C_LUI:  w_next = S_WB;
          C_LOAD, C_STORE:  w_next = S_MEM;
          C_BRANCH: begin
            w_pc   = branch_taken;
            w_next = S_FETCH;
          end
          C_JAL, C_JALR: begin
            w_pc   = 1'b1;
            w_next = S_WB;
          end
          default:          w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (r_class == C_LOAD) begin
          w_rd = 1'b1;
        end else begin
          w_wr = 1'b1;
        end
        if (mem_ready) begin
          w_next = (r_class == C_LOAD) ? S_WB : S_FETCH;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        w_rg   = 1'b1;
        w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // Strobes are held low for the whole time reset is asserted
  assign pcWrite  = w_pc & ~reset;
  assign irWrite  = w_ir & ~reset;
  assign memRead  = w_rd & ~reset;
  assign memWrite = w_wr & ~reset;
  assign regWrite = w_rg & ~reset;
  assign ALUop    = r_aluop;
  assign state    = r_state;
  assign illegal  = r_illegal;
  assign mem_err  = r_mem_err;

  // State, latched decode, timeout counter and sticky trap flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_class   <= C_R;
      r_aluop   <= '0;
      r_to_cnt  <= '0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_DECODE) && w_legal) begin
        r_class <= w_class;
        r_aluop <= w_aluop;
      end
      // Counter is zero whenever FETCH or MEM is entered
      if (w_mem_state && !mem_ready) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
      if ((r_state == S_DECODE) && !w_legal) begin
        r_illegal <= 1'b1;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_instret;
  logic [31:0] r_stall_cnt;

  // Retired-instruction and memory-stall counters; TRAP never satisfies either term
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instret   <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (((r_state == S_WB) || (r_state == S_EXEC) || (r_state == S_MEM)) &&
          (w_next == S_FETCH)) begin
        r_instret <= r_instret + 32'd1;
      end
      if (w_mem_state && !mem_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign instret   = r_instret;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: per-cycle stimulus and expected outputs are queued, then
// replayed against the DUT one clock at a time.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opCode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [6:0]  funct7 = 7'd0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        pcWrite, irWrite, memRead, memWrite, regWrite;
  logic [3:0]  ALUop;
  logic [2:0]  state;
  logic        illegal, mem_err;
`ifdef PERF_CNT_EN
  logic [31:0] instret, stall_cnt;
`endif

  multicycle_control_unit #(.ALUOP_W(4), .MEM_TIMEOUT(16), .TO_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .opCode       (opCode),
    .funct3       (funct3),
    .funct7       (funct7),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .pcWrite      (pcWrite),
    .irWrite      (irWrite),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .ALUop        (ALUop),
    .state        (state),
    .illegal      (illegal),
    .mem_err      (mem_err)
`ifdef PERF_CNT_EN
    ,
    .instret      (instret),
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // expected vector = {state[2:0], pcWrite, irWrite, memRead, memWrite, regWrite, illegal, mem_err}
  typedef struct {
    string      tag;
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       mr;
    logic       bt;
    logic [9:0] exp;
    logic [3:0] alu;
    logic       achk;
    int         e_ir;
    int         e_st;
  } cyc_t;

  cyc_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] PC = 5'b10000;
  localparam logic [4:0] IR = 5'b01000;
  localparam logic [4:0] RD = 5'b00100;
  localparam logic [4:0] WR = 5'b00010;
  localparam logic [4:0] RG = 5'b00001;
  localparam logic [4:0] NO = 5'b00000;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_LUI = 7;

  string      c_tag;
  logic [6:0] c_op;
  logic [2:0] c_f3;
  logic [6:0] c_f7;
  int         e_instret = 0;
  int         e_stall = 0;
  logic       e_ill = 1'b0;
  logic       e_me = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic px(input logic [2:0] st, input logic mr, input logic bt, input logic [4:0] strb,
                    input logic [3:0] alu, input logic achk, input logic last);
    cyc_t c;
    c.tag = c_tag; c.rst = 1'b0; c.op = c_op; c.f3 = c_f3; c.f7 = c_f7;
    c.mr = mr; c.bt = bt; c.exp = {st, strb, e_ill, e_me};
    c.alu = alu; c.achk = achk; c.e_ir = e_instret; c.e_st = e_stall;
    q.push_back(c);
    if (((st == 3'd0) || (st == 3'd3)) && !mr) e_stall++;
    if (last) e_instret++;
  endtask

  task automatic prst(input string tag);
    cyc_t c;
    e_instret = 0; e_stall = 0; e_ill = 1'b0; e_me = 1'b0;
    c.tag = tag; c.rst = 1'b1; c.op = 7'd0; c.f3 = 3'd0; c.f7 = 7'd0;
    c.mr = rb(); c.bt = rb(); c.exp = 10'd0;
    c.alu = 4'd0; c.achk = 1'b1; c.e_ir = 0; c.e_st = 0;
    q.push_back(c);
  endtask

  task automatic set_ins(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    c_tag = tag; c_op = op; c_f3 = f3; c_f7 = f7;
  endtask

  // Expected cycle sequence of one instruction, with fw/mw stall cycles in FETCH/MEM
  task automatic add_instr(input string tag, input int k, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [3:0] alu, input int fw, input int mw,
                           input logic taken);
    logic [4:0] s;
    set_ins(tag, op, f3, f7);
    for (int i = 0; i < fw; i++) px(3'd0, 1'b0, rb(), RD, 4'd0, 1'b0, 1'b0);
    px(3'd0, 1'b1, rb(), PC | IR | RD, 4'd0, 1'b0, 1'b0);
    px(3'd1, rb(), rb(), NO, 4'd0, 1'b0, 1'b0);
    s = ((k == K_JAL) || (k == K_JALR) || ((k == K_BR) && taken)) ? PC : NO;
    px(3'd2, rb(), taken, s, alu, 1'b1, (k == K_BR) ? 1'b1 : 1'b0);
    if ((k == K_LD) || (k == K_ST)) begin
      s = (k == K_LD) ? RD : WR;
      for (int i = 0; i < mw; i++) px(3'd3, 1'b0, rb(), s, alu, 1'b1, 1'b0);
      px(3'd3, 1'b1, rb(), s, alu, 1'b1, (k == K_ST) ? 1'b1 : 1'b0);
    end
    if ((k != K_BR) && (k != K_ST)) px(3'd4, rb(), rb(), RG, alu, 1'b1, 1'b1);
  endtask

  task automatic add_illegal(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input int n);
    set_ins(tag, op, f3, f7);
    px(3'd0, 1'b1, rb(), PC | IR | RD, 4'd0, 1'b0, 1'b0);
    px(3'd1, rb(), rb(), NO, 4'd0, 1'b0, 1'b0);
    e_ill = 1'b1;
    for (int i = 0; i < n; i++) px(3'd5, rb(), rb(), NO, 4'd0, 1'b0, 1'b0);
    prst({tag, "_rst"});
  endtask

  localparam logic [2:0]  R_F3 [8] = '{3'b000, 3'b110, 3'b111, 3'b011, 3'b001, 3'b101, 3'b100, 3'b010};
  localparam logic [3:0]  R_OP [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};

  initial begin
    cyc_t c;
    int   cyc = 0;

    prst("reset");
    add_instr("r_sub", K_R, 7'b0100001, 3'b110, 7'd0, 4'd1, 0, 0, 1'b0);
    for (int i = 0; i < 8; i++)
      add_instr($sformatf("r_f3_%0d", R_F3[i]), K_R, 7'b0100001, R_F3[i], 7'd0, R_OP[i], 0, 0, 1'b0);
    add_instr("addi", K_I, 7'b0001101, 3'b000, 7'($urandom), 4'd0, 0, 0, 1'b0);
    add_instr("ori",  K_I, 7'b0001101, 3'b011, 7'($urandom), 4'd3, 1, 0, 1'b0);
    add_instr("andi", K_I, 7'b0001101, 3'b111, 7'($urandom), 4'd2, 0, 0, 1'b0);
    add_instr("lui",  K_LUI, 7'b0100100, 3'($urandom), 7'($urandom), 4'd4, 0, 0, 1'b0);
    add_instr("jal",  K_JAL, 7'b1101111, 3'($urandom), 7'($urandom), 4'd0, 0, 0, 1'b0);
    add_instr("jalr", K_JALR, 7'b1000011, 3'($urandom), 7'($urandom), 4'd0, 2, 0, 1'b0);
    add_instr("load_w3", K_LD, 7'b0000011, 3'd2, 7'd0, 4'd0, 2, 3, 1'b0);
    add_instr("store", K_ST, 7'b0010111, 3'd2, 7'd0, 4'd0, 0, 0, 1'b0);
    add_instr("store_w1", K_ST, 7'b0010111, 3'd2, 7'd0, 4'd0, 0, 1, 1'b0);
    add_instr("br_nt", K_BR, 7'b1100011, 3'd0, 7'd0, 4'd1, 0, 0, 1'b0);
    add_instr("br_t",  K_BR, 7'b1100011, 3'd0, 7'd0, 4'd1, 0, 0, 1'b1);
    add_instr("fetch_edge", K_R, 7'b0100001, 3'b000, 7'd0, 4'd0, 16, 0, 1'b0);
    add_instr("mem_edge", K_LD, 7'b0000011, 3'd2, 7'd0, 4'd0, 0, 16, 1'b0);

    // reset while a store is holding memWrite in MEM
    set_ins("mid_mem", 7'b0010111, 3'd0, 7'd0);
    px(3'd0, 1'b1, 1'b0, PC | IR | RD, 4'd0, 1'b0, 1'b0);
    px(3'd1, 1'b0, 1'b0, NO, 4'd0, 1'b0, 1'b0);
    px(3'd2, 1'b0, 1'b0, NO, 4'd0, 1'b1, 1'b0);
    px(3'd3, 1'b0, 1'b0, WR, 4'd0, 1'b1, 1'b0);
    prst("mid_mem_rst");

    add_illegal("op_7f", 7'b1111111, 3'd0, 7'd0, 20);
    add_illegal("r_bad_f7", 7'b0100001, 3'b000, 7'b0100000, 4);
    add_illegal("i_bad_f3", 7'b0001101, 3'b001, 7'd0, 4);

    set_ins("fetch_to", 7'b0100001, 3'd0, 7'd0);
    for (int i = 0; i < 17; i++) px(3'd0, 1'b0, rb(), RD, 4'd0, 1'b0, 1'b0);
    e_me = 1'b1;
    for (int i = 0; i < 5; i++) px(3'd5, rb(), rb(), NO, 4'd0, 1'b0, 1'b0);
    prst("fetch_to_rst");

    set_ins("mem_to", 7'b0000011, 3'd2, 7'd0);
    add_instr("pre_to", K_R, 7'b0100001, 3'b111, 7'd0, 4'd2, 0, 0, 1'b0);
    set_ins("mem_to", 7'b0000011, 3'd2, 7'd0);
    px(3'd0, 1'b1, 1'b0, PC | IR | RD, 4'd0, 1'b0, 1'b0);
    px(3'd1, 1'b0, 1'b0, NO, 4'd0, 1'b0, 1'b0);
    px(3'd2, 1'b0, 1'b0, NO, 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) px(3'd3, 1'b0, rb(), RD, 4'd0, 1'b1, 1'b0);
    e_me = 1'b1;
    for (int i = 0; i < 4; i++) px(3'd5, rb(), rb(), NO, 4'd0, 1'b1, 1'b0);
    prst("mem_to_rst");
    add_instr("post", K_R, 7'b0100001, 3'b100, 7'd0, 4'd6, 0, 0, 1'b0);

    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      reset        = c.rst;
      opCode       = c.op;
      funct3       = c.f3;
      funct7       = c.f7;
      mem_ready    = c.mr;
      branch_taken = c.bt;
      #1;
      check_eq($sformatf("%s@%0d out", c.tag, cyc),
               {22'd0, state, pcWrite, irWrite, memRead, memWrite, regWrite, illegal, mem_err},
               {22'd0, c.exp});
      if (c.achk) check_eq($sformatf("%s@%0d alu", c.tag, cyc), {28'd0, ALUop}, {28'd0, c.alu});
`ifdef PERF_CNT_EN
      check_eq($sformatf("%s@%0d instret", c.tag, cyc), instret, 32'(c.e_ir));
      check_eq($sformatf("%s@%0d stall", c.tag, cyc), stall_cnt, 32'(c.e_st));
`endif
      cyc++;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
